stepped_shifter: RTL and testbench

//  Multi-cycle, mode-selectable shifter; successor to the single-function shifter.

---
 rtl/shifter_pkg.sv | 27 ++
 rtl/shift_step.sv | 61 ++++++
 rtl/stepped_shifter.sv | 151 +++++++++++++++
 tb/tb_stepped_shifter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the stepped shifter.
//   - Mode encodings for i_mode (SHIFT_LSL .. SHIFT_ROR); 101-111 are reserved.
//   - FSM state type used by the top level and exposed on its debug port.
//   - Small helpers that classify a mode.
package shifter_pkg;

  localparam logic [2:0] SHIFT_LSL = 3'b000;
  localparam logic [2:0] SHIFT_LSR = 3'b001;
  localparam logic [2:0] SHIFT_ASR = 3'b010;
  localparam logic [2:0] SHIFT_ROL = 3'b011;
  localparam logic [2:0] SHIFT_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_rotate(input logic [2:0] mode);
    return (mode == SHIFT_ROL) || (mode == SHIFT_ROR);
  endfunction

  function automatic logic is_reserved(input logic [2:0] mode);
    return mode > SHIFT_ROR;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the stepped shifter.
// Moves i_value by i_k places (0..STEP) in the direction/fill chosen by i_mode
// and reports the last bit that left the word during this step.
// Ports:
//   i_value  in  N   word before the step
//   i_mode   in  3   operation (shifter_pkg encodings)
//   i_k      in  KW  places to move this step; 0 passes the word through
//   o_value  out N   word after the step
//   o_carry  out 1   last bit shifted/rotated out (0 when i_k == 0 or reserved mode)
module shift_step
  import shifter_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  i_value,
  input  logic [2:0]    i_mode,
  input  logic [KW-1:0] i_k,
  output logic [N-1:0]  o_value,
  output logic          o_carry
);

  int k;

  always_comb begin
    k       = int'(i_k);
    o_value = i_value;
    o_carry = 1'b0;
    // k == 0 is excluded so that the carry indices below stay inside the word.
    if (k != 0) begin
      case (i_mode)
        SHIFT_LSL: begin
          o_value = i_value << k;
          o_carry = i_value[N-k];
        end
        SHIFT_LSR: begin
          o_value = i_value >> k;
          o_carry = i_value[k-1];
        end
        SHIFT_ASR: begin
          o_value = $unsigned($signed(i_value) >>> k);
          o_carry = i_value[k-1];
        end
        SHIFT_ROL: begin
          o_value = (i_value << k) | (i_value >> (N - k));
          o_carry = i_value[N-k];
        end
        SHIFT_ROR: begin
          o_value = (i_value >> k) | (i_value << (N - k));
          o_carry = i_value[k-1];
        end
        default: begin
          o_value = i_value;
          o_carry = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stepped_shifter.sv
// Multi-cycle, mode-selectable shifter (LSL, LSR, ASR, ROL, ROR) that moves up
// to STEP bit positions per clock, with carry-out and zero flags.
// Ports:
//   i_clock      in  1             clock, rising edge
//   i_reset      in  1             synchronous active-high reset
//   i_start      in  1             request, accepted in IDLE or DONE
//   i_mode       in  3             operation (shifter_pkg encodings)
//   i_amount     in  AMOUNT_WIDTH  shift/rotate distance
//   i_value      in  N             operand, sampled on accept
//   o_busy       out 1             operation in progress (SHIFT)
//   o_finished   out 1             one-cycle pulse, o_value valid (DONE)
//   o_value      out N             result / working register
//   o_carry      out 1             last bit moved out
//   o_zero       out 1             o_value == 0
//   o_dbg_state  out state_e       current FSM state
//
// Handshake: a request is taken on any rising edge where i_start is high and
// the FSM is in IDLE or DONE; i_mode/i_amount/i_value are sampled on that edge
// only. While o_busy is high i_start is ignored (not queued). o_finished is
// high for exactly the one cycle in DONE, and o_value/o_carry/o_zero then hold
// until the next accepted start.
module stepped_shifter
  import shifter_pkg::*;
#(
  parameter int N            = 8,
  parameter int STEP         = 1,
  parameter int AMOUNT_WIDTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [2:0]              i_mode,
  input  logic [AMOUNT_WIDTH-1:0] i_amount,
  input  logic [N-1:0]            i_value,
  output logic                    o_busy,
  output logic                    o_finished,
  output logic [N-1:0]            o_value,
  output logic                    o_carry,
  output logic                    o_zero,
  output state_e                  o_dbg_state
);

  // The down-counter must hold both the raw rotate amount and the clamp value N.
  localparam int CW = (AMOUNT_WIDTH > $clog2(N + 1)) ? AMOUNT_WIDTH : $clog2(N + 1);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP);

  state_e        state_q, state_d;
  logic [N-1:0]  value_q, value_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] remaining_q, remaining_d;

  logic          accept;
  logic [CW-1:0] eff_amount;
  logic [KW-1:0] step_k;
  logic [N-1:0]  step_value;
  logic          step_carry;

  assign accept = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Linear shifts saturate at N (word fully flushed); rotates keep the full
  // amount so latency follows the requested distance. Reserved modes pass through.
  always_comb begin
    eff_amount = CW'(i_amount);
    if (is_reserved(i_mode)) begin
      eff_amount = '0;
    end else if (!is_rotate(i_mode) && (eff_amount > N_CNT)) begin
      eff_amount = N_CNT;
    end
  end

  assign step_k = (remaining_q > STEP_CNT) ? KW'(STEP) : KW'(remaining_q);

  shift_step #(
    .N    (N),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .i_value (value_q),
    .i_mode  (mode_q),
    .i_k     (step_k),
    .o_value (step_value),
    .o_carry (step_carry)
  );

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          value_d     = i_value;
          mode_d      = i_mode;
          remaining_d = eff_amount;
          carry_d     = 1'b0;
          zero_d      = (i_value == '0);
          state_d     = (eff_amount == '0) ? ST_DONE : ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        value_d = step_value;
        carry_d = step_carry;
        zero_d  = (step_value == '0);
        if (remaining_q > STEP_CNT) begin
          remaining_d = remaining_q - STEP_CNT;
        end else begin
          remaining_d = '0;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      mode_q      <= SHIFT_LSL;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  assign o_busy      = (state_q == ST_SHIFT);
  assign o_finished  = (state_q == ST_DONE);
  assign o_value     = value_q;
  assign o_carry     = carry_q;
  assign o_zero      = zero_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_stepped_shifter.sv
// Bench for stepped_shifter: dut_a uses N=8/STEP=1, dut_b uses N=8/STEP=3.
// Latency is counted in rising edges after the accepting edge until
// o_finished is seen high; a zero-amount request reaches DONE on the
// accepting edge itself, so o_finished is high in the very next cycle.
module tb_stepped_shifter;
  import shifter_pkg::*;

  logic clk;
  logic rst;

  logic       a_start, a_busy, a_fin, a_carry, a_zero;
  logic [2:0] a_mode;
  logic [3:0] a_amount;
  logic [7:0] a_value, a_out;
  state_e     a_state;

  logic       b_start, b_busy, b_fin, b_carry, b_zero;
  logic [2:0] b_mode;
  logic [3:0] b_amount;
  logic [7:0] b_value, b_out;
  state_e     b_state;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  stepped_shifter #(.N(8), .STEP(1), .AMOUNT_WIDTH(4)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_mode(a_mode),
    .i_amount(a_amount), .i_value(a_value), .o_busy(a_busy),
    .o_finished(a_fin), .o_value(a_out), .o_carry(a_carry),
    .o_zero(a_zero), .o_dbg_state(a_state)
  );

  stepped_shifter #(.N(8), .STEP(3), .AMOUNT_WIDTH(4)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_mode(b_mode),
    .i_amount(b_amount), .i_value(b_value), .o_busy(b_busy),
    .o_finished(b_fin), .o_value(b_out), .o_carry(b_carry),
    .o_zero(b_zero), .o_dbg_state(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] value;
    logic [7:0] exp_value;
    logic       exp_carry;
    logic       exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: move one place at a time, carry is the bit that left last.
  function automatic void ref_shift(input logic [2:0] m, input logic [3:0] a,
                                    input logic [7:0] v, output logic [7:0] r,
                                    output logic c, output int eff);
    eff = int'(a);
    if (m > 3'd4) eff = 0;
    else if (m <= 3'd2 && eff > 8) eff = 8;
    r = v;
    c = 1'b0;
    for (int s = 0; s < eff; s++) begin
      case (m)
        3'd0: begin c = r[7]; r = {r[6:0], 1'b0}; end
        3'd1: begin c = r[0]; r = {1'b0, r[7:1]}; end
        3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
        3'd3: begin c = r[7]; r = {r[6:0], r[7]}; end
        default: begin c = r[0]; r = {r[0], r[7:1]}; end
      endcase
    end
  endfunction

  // driver: one request on dut_a, waits for o_finished (bounded)
  task automatic run_a(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] v,
                       output int lat, output logic timeout);
    @(negedge clk);
    a_start = 1'b1; a_mode = m; a_amount = amt; a_value = v;
    @(posedge clk); #1;
    a_start  = 1'b0;
    a_mode   = 3'($urandom_range(0, 7));
    a_amount = 4'($urandom_range(0, 15));
    a_value  = 8'($urandom_range(0, 255));
    lat = 0; timeout = 1'b0;
    while (!a_fin) begin
      if (lat >= 40) begin timeout = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_b(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] v,
                       output int lat, output logic timeout);
    @(negedge clk);
    b_start = 1'b1; b_mode = m; b_amount = amt; b_value = v;
    @(posedge clk); #1;
    b_start = 1'b0;
    lat = 0; timeout = 1'b0;
    while (!b_fin) begin
      if (lat >= 40) begin timeout = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic to;
    logic [7:0] r;
    logic c;
    int eff;
    logic [8:0] exp;
    logic [2:0] m;
    logic [3:0] amt;
    logic [7:0] v;
    int pulses;
    int last;
    logic fin_seen;

    //            mode       amt    value  exp    c     z     lat
    vecs[0]  = '{SHIFT_LSL, 4'd3,  8'h03, 8'h18, 1'b0, 1'b0, 3};
    vecs[1]  = '{SHIFT_ASR, 4'd1,  8'h81, 8'hC0, 1'b1, 1'b0, 1};
    vecs[2]  = '{SHIFT_LSR, 4'd15, 8'hFF, 8'h00, 1'b1, 1'b1, 8};
    vecs[3]  = '{SHIFT_ROL, 4'd9,  8'h81, 8'h03, 1'b1, 1'b0, 9};
    vecs[4]  = '{SHIFT_ROR, 4'd1,  8'h81, 8'hC0, 1'b1, 1'b0, 1};
    vecs[5]  = '{SHIFT_LSL, 4'd0,  8'h5A, 8'h5A, 1'b0, 1'b0, 0};
    vecs[6]  = '{3'b111,    4'd4,  8'hA5, 8'hA5, 1'b0, 1'b0, 0};
    vecs[7]  = '{3'b101,    4'd3,  8'h00, 8'h00, 1'b0, 1'b1, 0};
    vecs[8]  = '{SHIFT_LSL, 4'd8,  8'h01, 8'h00, 1'b1, 1'b1, 8};
    vecs[9]  = '{SHIFT_ASR, 4'd12, 8'h80, 8'hFF, 1'b1, 1'b0, 8};
    vecs[10] = '{SHIFT_LSR, 4'd2,  8'h96, 8'h25, 1'b1, 1'b0, 2};
    vecs[11] = '{SHIFT_ROR, 4'd15, 8'h01, 8'h02, 1'b0, 1'b0, 15};
    vecs[12] = '{SHIFT_ASR, 4'd3,  8'h40, 8'h08, 1'b0, 1'b0, 3};
    vecs[13] = '{SHIFT_ROL, 4'd4,  8'h00, 8'h00, 1'b0, 1'b1, 4};

    rst = 1'b1;
    a_start = 1'b0; a_mode = '0; a_amount = '0; a_value = '0;
    b_start = 1'b0; b_mode = '0; b_amount = '0; b_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset a_busy", 32'(a_busy), 32'd0);
    check("reset a_finished", 32'(a_fin), 32'd0);
    check("reset a_value", 32'(a_out), 32'd0);
    check("reset a_carry", 32'(a_carry), 32'd0);
    check("reset a_zero", 32'(a_zero), 32'd1);
    check("reset a_state", 32'(a_state), 32'(ST_IDLE));
    check("reset b_zero", 32'(b_zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors on dut_a
    for (int i = 0; i < 14; i++) begin
      run_a(vecs[i].mode, vecs[i].amount, vecs[i].value, lat, to);
      check($sformatf("v%0d timeout", i), 32'(to), 32'd0);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d value", i), 32'(a_out), 32'(vecs[i].exp_value));
      check($sformatf("v%0d carry", i), 32'(a_carry), 32'(vecs[i].exp_carry));
      check($sformatf("v%0d zero", i), 32'(a_zero), 32'(vecs[i].exp_zero));
      @(posedge clk); #1;
      check($sformatf("v%0d pulse end", i), 32'(a_fin), 32'd0);
      check($sformatf("v%0d held value", i), 32'(a_out), 32'(vecs[i].exp_value));
    end

    // random requests against the reference model
    for (int i = 0; i < 24; i++) begin
      m   = 3'($urandom_range(0, 7));
      amt = 4'($urandom_range(0, 15));
      v   = 8'($urandom_range(0, 255));
      ref_shift(m, amt, v, r, c, eff);
      exp_q.push_back({c, r});
      run_a(m, amt, v, lat, to);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d timeout", i), 32'(to), 32'd0);
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(eff));
      check($sformatf("rnd%0d carry_value", i), {23'd0, a_carry, a_out}, {23'd0, exp});
      check($sformatf("rnd%0d zero", i), 32'(a_zero), 32'(exp[7:0] == 8'h00));
    end

    // start while busy: second request must be dropped
    @(negedge clk);
    a_start = 1'b1; a_mode = SHIFT_LSL; a_amount = 4'd3; a_value = 8'h03;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    a_start = 1'b1; a_mode = SHIFT_ROR; a_amount = 4'd1; a_value = 8'h55;
    @(posedge clk); #1;
    a_start = 1'b0;
    lat = 1;
    while (!a_fin && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_ignore latency", 32'(lat), 32'd3);
    check("busy_ignore value", 32'(a_out), 32'h18);
    check("busy_ignore carry", 32'(a_carry), 32'd0);
    @(posedge clk); #1;
    check("busy_ignore no queue busy", 32'(a_busy), 32'd0);
    check("busy_ignore no queue fin", 32'(a_fin), 32'd0);

    // reset mid-SHIFT
    @(negedge clk);
    a_start = 1'b1; a_mode = SHIFT_LSR; a_amount = 4'd8; a_value = 8'hFF;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset busy before", 32'(a_busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", 32'(a_busy), 32'd0);
    check("midreset finished", 32'(a_fin), 32'd0);
    check("midreset value", 32'(a_out), 32'd0);
    check("midreset carry", 32'(a_carry), 32'd0);
    check("midreset zero", 32'(a_zero), 32'd1);
    check("midreset state", 32'(a_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    fin_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (a_fin) fin_seen = 1'b1;
    end
    check("midreset no finished", 32'(fin_seen), 32'd0);

    // STEP=3 unit
    run_b(SHIFT_LSL, 4'd7, 8'h01, lat, to);
    check("b lsl7 timeout", 32'(to), 32'd0);
    check("b lsl7 latency", 32'(lat), 32'd3);
    check("b lsl7 value", 32'(b_out), 32'h80);
    check("b lsl7 carry", 32'(b_carry), 32'd0);
    run_b(SHIFT_ROL, 4'd10, 8'h81, lat, to);
    ref_shift(SHIFT_ROL, 4'd10, 8'h81, r, c, eff);
    check("b rol10 latency", 32'(lat), 32'((eff + 2) / 3));
    check("b rol10 value", 32'(b_out), 32'(r));
    check("b rol10 carry", 32'(b_carry), 32'(c));
    run_b(SHIFT_ASR, 4'd5, 8'h90, lat, to);
    check("b asr5 latency", 32'(lat), 32'd2);
    check("b asr5 value", 32'(b_out), 32'hFC);
    check("b asr5 carry", 32'(b_carry), 32'd1);
    @(posedge clk); #1;

    // start held high: every DONE accepts the next request
    @(negedge clk);
    b_start = 1'b1; b_mode = SHIFT_LSL; b_amount = 4'd7; b_value = 8'h01;
    pulses = 0;
    last = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (b_fin) begin
        pulses++;
        check($sformatf("b2b value c%0d", cyc), 32'(b_out), 32'h80);
        check($sformatf("b2b gap c%0d", cyc), 32'(cyc - last), (last < 0) ? 32'd4 : 32'd4);
        last = cyc;
      end
    end
    b_start = 1'b0;
    check("b2b pulses", 32'(pulses), 32'd4);
    check("b2b last pulse cycle", 32'(last), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
